s2m_pipe: RTL
=============

S2M_PIPE -- requirements
Module: s2m_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 256, payload width in bits.
REQ-002 Parameter CNT_WIDTH, default 32, statistics counter width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pipe_in_valid  input  1  upstream beat valid.
REQ-006 pipe_in_data  input  DATA_WIDTH  upstream payload.
REQ-007 pipe_in_ready  output  1  upstream may transfer; driven directly from a flop.
REQ-008 pipe_out_valid  output  1  downstream beat valid.
REQ-009 pipe_out_data  output  DATA_WIDTH  downstream payload.
REQ-010 pipe_out_ready  input  1  downstream accepts beat.
REQ-011 stats_clr  input  1  synchronous clear of all statistics counters.
REQ-012 xfer_cnt  output  CNT_WIDTH  count of completed output transfers.
REQ-013 stall_cnt  output  CNT_WIDTH  count of cycles with pipe_out_valid=1 and pipe_out_ready=0.
REQ-014 skid_cnt  output  CNT_WIDTH  count of PASS->SKID transitions.

Function
REQ-015 Block SHALL be a backward (ready-path) register slice: pipe_in_ready has no combinational path from pipe_out_ready; valid/data pass combinationally when skid empty.
REQ-016 Two-state FSM: PASS (skid buffer empty), SKID (skid buffer holds one beat).
REQ-017 PASS: pipe_out_valid = pipe_in_valid, pipe_out_data = pipe_in_data, pipe_in_ready = 1.
REQ-018 PASS -> SKID when pipe_in_valid=1 and pipe_out_ready=0; skid buffer captures pipe_in_data that edge.
REQ-019 SKID: pipe_out_valid = 1, pipe_out_data = skid buffer, pipe_in_ready = 0.
REQ-020 SKID -> PASS when pipe_out_ready=1; pipe_in_valid ignored while in SKID.
REQ-021 Zero added latency in PASS; one beat of buffering; no beat dropped, duplicated or reordered.
REQ-022 pipe_in_ready SHALL be a flop loaded with (next_state == PASS) each cycle.
REQ-023 Skid buffer SHALL load only on PASS->SKID; it need not be reset.
REQ-024 Upstream SHALL hold pipe_in_valid/pipe_in_data stable while pipe_in_ready=0; the block does not sample them then.
REQ-025 Counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-026 stats_clr=1 SHALL zero all counters that cycle; clear has priority over a coincident increment.
REQ-027 xfer_cnt increments when pipe_out_valid=1 and pipe_out_ready=1; stall_cnt and skid_cnt per REQ-013/014.

Reset
REQ-028 reset=1 SHALL force state PASS, pipe_in_ready=0, all counters 0; skid contents discarded.
REQ-029 pipe_out_valid SHALL be 0 during reset (gated by reset).
REQ-030 pipe_in_ready SHALL rise on the first edge after reset deasserts.
REQ-031 Reset asserted while in SKID SHALL drop the buffered beat; state PASS after deassert.

Configuration
REQ-032 Macro S2M_PIPE_STATS_EN: defined -> counters and stats_clr implemented per REQ-025..027.
REQ-033 S2M_PIPE_STATS_EN undefined -> ports remain, xfer_cnt/stall_cnt/skid_cnt tied to 0, stats_clr ignored, no counter flops.

Verification
REQ-034 Reset release, pipe_out_ready=1, beats 0x01..0x10 back-to-back -> output identical same cycle, pipe_in_ready=1 throughout, xfer_cnt=16.
REQ-035 Beat 0xA5 while pipe_out_ready=0 -> next cycle SKID, pipe_in_ready=0, pipe_out_data=0xA5; ready=1 two cycles later -> 0xA5 delivered once, skid_cnt=1.
REQ-036 Random 50% valid / 50% ready, 10000 beats of incrementing data -> scoreboard exact in-order match, xfer_cnt=10000.
REQ-037 Reset asserted for one cycle while in SKID holding 0x3C -> 0x3C never output, pipe_in_ready=0 during reset, 1 next cycle.
REQ-038 CNT_WIDTH=4, 20 stall cycles -> stall_cnt=15 held; stats_clr pulse coincident with a stall -> stall_cnt=0.
REQ-039 Build without S2M_PIPE_STATS_EN, repeat REQ-036 -> data identical, all counters 0.

Source files
------------

// File: rtl/s2m_pipe.sv
// s2m_pipe: backward (ready-path) register slice with a one-beat skid buffer.
// pipe_in_ready comes straight from a flop, so there is no combinational path
// from pipe_out_ready to pipe_in_ready. While the skid buffer is empty, valid
// and data pass through with zero latency.
//
// Build option: define S2M_PIPE_STATS_EN to implement the saturating
// xfer/stall/skid statistics counters and stats_clr. Without it the counter
// ports read 0, stats_clr is ignored and no counter flops are built.
//
// state | meaning
// ------+-----------------------------------------------------------
// PASS  | skid buffer empty; upstream beat forwarded combinationally
// SKID  | skid buffer holds one beat; upstream held off (ready low)

module s2m_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_in_valid,
  input  logic [DATA_WIDTH-1:0] pipe_in_data,
  output logic                  pipe_in_ready,
  output logic                  pipe_out_valid,
  output logic [DATA_WIDTH-1:0] pipe_out_data,
  input  logic                  pipe_out_ready,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  skid_cnt
);

  typedef enum logic {
    PASS = 1'b0,
    SKID = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  in_ready_q;
  logic                  load_skid;
  logic [DATA_WIDTH-1:0] skid_data;

  assign pipe_in_ready = in_ready_q;

  // Next state, skid load strobe and output muxing.
  // An upstream beat is only taken while the ready flop is high. This keeps
  // the first cycle after reset release (ready still low) from forwarding a
  // beat that upstream does not consider transferred.
  always_comb begin
    state_nxt      = state;
    load_skid      = 1'b0;
    pipe_out_valid = 1'b0;
    pipe_out_data  = pipe_in_data;
    case (state)
      PASS: begin
        pipe_out_valid = pipe_in_valid & in_ready_q & ~reset;
        if (pipe_in_valid && in_ready_q && !pipe_out_ready) begin
          state_nxt = SKID;
          load_skid = 1'b1;
        end
      end
      SKID: begin
        pipe_out_valid = ~reset;
        pipe_out_data  = skid_data;
        if (pipe_out_ready) begin
          state_nxt = PASS;
        end
      end
      default: begin
        state_nxt = PASS;
      end
    endcase
  end

  // State register and registered upstream ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PASS;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == PASS);
    end
  end

  // Skid buffer: captures the stalled beat on PASS->SKID only, never reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data <= pipe_in_data;
    end
  end

`ifdef S2M_PIPE_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 xfer_evt;
  logic                 stall_evt;
  logic [CNT_WIDTH-1:0] xfer_q;
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] skid_q;

  assign xfer_evt  = pipe_out_valid & pipe_out_ready;
  assign stall_evt = pipe_out_valid & ~pipe_out_ready;

  // Completed output transfers; saturates, clear beats increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      xfer_q <= '0;
    end else if (xfer_evt && !(&xfer_q)) begin
      xfer_q <= xfer_q + CNT_ONE;
    end
  end

  // Cycles with valid output held off by downstream; saturating.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      stall_q <= '0;
    end else if (stall_evt && !(&stall_q)) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

  // PASS->SKID transitions; saturating.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      skid_q <= '0;
    end else if (load_skid && !(&skid_q)) begin
      skid_q <= skid_q + CNT_ONE;
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
  assign skid_cnt  = skid_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign xfer_cnt         = '0;
  assign stall_cnt        = '0;
  assign skid_cnt         = '0;
`endif

endmodule
